uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It supports compile-time data width (5-9 bits), parity mode, 1 or 2 stop bits, and a ready/valid input handshake. It sits between the byte-producing logic and the serial TX pin. An optional input FIFO allows back-to-back frames without upstream stalls.

---
 rtl/uart_tx_cfg.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with ready/valid input.
// Define UART_TX_FIFO_EN to place an input FIFO in front of the FSM.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_serial;
  logic                 r_active;
  logic                 r_done;
  logic                 r_ready;

  logic                 w_go;
  logic [DATA_BITS-1:0] w_word;
  logic                 w_bit_end;

  assign w_bit_end = (r_cnt == C_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_rd;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_go       = (r_count != '0);
  assign w_word     = r_mem[r_rd_ptr];
  assign w_wr       = i_Tx_DV && !w_full;
  assign w_rd       = w_go && r_ready;
  assign o_Tx_Ready = !w_full;

  // FIFO storage: written on accept, no reset needed on the data.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_Tx_Byte;
    end
  end

  // FIFO pointers and occupancy; write and pop together keep the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  assign w_go       = i_Tx_DV;
  assign w_word     = i_Tx_Byte;
  assign o_Tx_Ready = r_ready;
`endif

  // Frame sequencer: all line/status outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_stop   <= 1'b0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_cnt    <= '0;
          r_idx    <= '0;
          r_stop   <= 1'b0;
          if (w_go) begin
            r_shift  <= w_word;
            r_par    <= (^w_word) ^ ODD;
            r_state  <= S_START;
            r_serial <= 1'b0;
            r_active <= 1'b1;
            r_ready  <= 1'b0;
          end else begin
            r_state  <= S_IDLE;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_state  <= S_DATA;
            r_serial <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == I_LAST) begin
              if (PARITY != 0) begin
                r_state  <= S_PARITY;
                r_serial <= r_par;
              end else begin
                r_state  <= S_STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_shift  <= r_shift >> 1;
              r_serial <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          r_serial <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop == S_LAST) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_active <= 1'b0;
              r_ready  <= 1'b1;
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_stop   <= 1'b0;
          r_serial <= 1'b1;
          r_active <= 1'b0;
          r_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_active;
  assign o_Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four configurations of uart_tx_cfg against a
// frame-position model, plus hand-computed frame literals.
module tb_uart_tx_cfg;

`ifdef UART_TX_FIFO_EN
  localparam bit FIFO = 1'b1;
  localparam int LAT  = 1;
`else
  localparam bit FIFO = 1'b0;
  localparam int LAT  = 0;
`endif
  localparam int DEPTH = 4;
  localparam int LOGN  = 2048;

  localparam int CPB [4] = '{4, 4, 4, 2};
  localparam int NB  [4] = '{8, 7, 7, 9};
  localparam int PAR [4] = '{0, 2, 1, 0};
  localparam int STP [4] = '{1, 2, 2, 1};

  logic       clk;
  logic       rst_n;
  logic       dv  [4];
  logic [8:0] bq  [4];
  logic       rdy [4];
  logic       ser [4];
  logic       act [4];
  logic       dn  [4];

  int n_chk;
  int n_fail;
  int cyc;
  bit chk_on;

  int         pos [4];
  logic [8:0] cur [4];
  int         cnt [4];
  int         rp  [4];
  logic [8:0] fq  [4][DEPTH];
  bit         acc [4];

  logic lser [4][LOGN];
  logic lact [4][LOGN];
  logic ldn  [4][LOGN];
  logic lrdy [4][LOGN];

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Tx_DV(dv[0]),
    .i_Tx_Byte(bq[0][7:0]), .o_Tx_Ready(rdy[0]),
    .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(dn[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Tx_DV(dv[1]),
    .i_Tx_Byte(bq[1][6:0]), .o_Tx_Ready(rdy[1]),
    .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(dn[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1),
                .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Tx_DV(dv[2]),
    .i_Tx_Byte(bq[2][6:0]), .o_Tx_Ready(rdy[2]),
    .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(dn[2]));

  uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Tx_DV(dv[3]),
    .i_Tx_Byte(bq[3]), .o_Tx_Ready(rdy[3]),
    .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(dn[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int flen(int i);
    return CPB[i] * (1 + NB[i] + ((PAR[i] != 0) ? 1 : 0) + STP[i]);
  endfunction

  // Line value of bit period k of a frame carrying word w.
  function automatic logic exp_bit(int i, logic [8:0] w, int k);
    logic p;
    p = 1'b0;
    for (int j = 0; j < NB[i]; j++) p = p ^ w[j];
    if (PAR[i] == 1) p = ~p;
    if (k == 0) return 1'b0;
    if (k <= NB[i]) return w[k-1];
    if (PAR[i] != 0 && k == NB[i] + 1) return p;
    return 1'b1;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit fr, wr, pp;
    int f;
    f  = flen(i);
    fr = (pos[i] < 0) || (pos[i] == f);
    if (FIFO) begin
      wr = dv[i] && (cnt[i] < DEPTH);
      pp = fr && (cnt[i] > 0);
    end else begin
      wr = dv[i] && fr;
      pp = wr;
    end
    if (pp) begin
      cur[i] = FIFO ? fq[i][rp[i]] : bq[i];
      pos[i] = 0;
    end else if (pos[i] == f) begin
      pos[i] = -1;
    end else if (pos[i] >= 0) begin
      pos[i] = pos[i] + 1;
    end
    if (FIFO) begin
      if (pp) begin
        rp[i]  = (rp[i] + 1) % DEPTH;
        cnt[i] = cnt[i] - 1;
      end
      if (wr) begin
        fq[i][(rp[i] + cnt[i]) % DEPTH] = bq[i];
        cnt[i] = cnt[i] + 1;
      end
    end
    acc[i] = wr;
  endtask

  initial cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        pos[i] = -1;
        cnt[i] = 0;
        rp[i]  = 0;
        acc[i] = 1'b0;
        cur[i] = '0;
      end else begin
        model_step(i);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      int f;
      logic es, ea, ed, er;
      f  = flen(i);
      es = (pos[i] < 0 || pos[i] >= f) ? 1'b1
           : exp_bit(i, cur[i], pos[i] / CPB[i]);
      ea = (pos[i] >= 0) && (pos[i] < f);
      ed = (pos[i] == f);
      er = FIFO ? (cnt[i] < DEPTH) : (pos[i] < 0 || pos[i] == f);
      if (rst_n && chk_on)
        check($sformatf("cmp_u%0d", i),
              {ser[i], act[i], dn[i], rdy[i]}, {es, ea, ed, er});
      if (cyc < LOGN) begin
        lser[i][cyc] = ser[i];
        lact[i][cyc] = act[i];
        ldn[i][cyc]  = dn[i];
        lrdy[i][cyc] = rdy[i];
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic frame_lit(input string nm, input int i, input int s,
                           input logic [15:0] lit, input int nb);
    logic [15:0] g;
    g = '0;
    for (int k = 0; k < nb; k++)
      g[k] = lser[i][s + k*CPB[i] + CPB[i]/2];
    check(nm, g, lit);
  endtask

  task automatic done_lit(input string nm, input int i, input int s,
                          input int len);
    int t, na;
    t  = -1;
    na = 0;
    for (int j = s + 60; j >= s; j--) if (ldn[i][j]) t = j;
    for (int j = s; j <= s + 60; j++) if (lact[i][j]) na++;
    check({nm, "_done"}, t - s, len);
    check({nm, "_act"}, na, len);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, s, k;
    logic [8:0] w [5];
    logic [15:0] fl [5];
    n_chk  = 0;
    n_fail = 0;
    chk_on = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dv[i] = 1'b0;
      bq[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_u%0d", i),
            {ser[i], act[i], dn[i], rdy[i]}, 4'b1001);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    e = cyc + 1;
    bq[0] = 9'h0A5; bq[1] = 9'h055; bq[2] = 9'h055; bq[3] = 9'h1FF;
    for (int i = 0; i < 4; i++) dv[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) dv[i] = 1'b0;
    s = e + LAT;
    wait_cyc(s + 62);
    frame_lit("t1_a5_bits", 0, s, 16'h034A, 10);
    done_lit("t1_a5", 0, s, 40);
    frame_lit("t2_even_bits", 1, s, 16'h06AA, 11);
    done_lit("t2_even", 1, s, 44);
    frame_lit("t2_odd_bits", 2, s, 16'h07AA, 11);
    done_lit("t2_odd", 2, s, 44);
    frame_lit("t6_1ff_bits", 3, s, 16'h07FE, 11);
    done_lit("t6_1ff", 3, s, 22);

    e = cyc + 1;
    bq[0] = 9'h0FF;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    s = e + LAT;
    wait_cyc(s + 9);
    bq[0] = 9'h03C;
    dv[0] = 1'b1;
`ifndef UART_TX_FIFO_EN
    check("t3_busy_ready", rdy[0], 1'b0);
`endif
    @(negedge clk);
    dv[0] = 1'b0;
    wait_cyc(s + 40);
`ifndef UART_TX_FIFO_EN
    check("t3_done_pulse", dn[0], 1'b1);
`endif
    bq[0] = 9'h00F;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    wait_cyc(s + 41 + 130);
    frame_lit("t3_ff_bits", 0, s, 16'h03FE, 10);
`ifndef UART_TX_FIFO_EN
    check("t3_gap", {lser[0][s+40], lser[0][s+41]}, 2'b10);
    frame_lit("t3_0f_bits", 0, s + 41, 16'h021E, 10);
`endif

    e = cyc + 1;
    bq[0] = 9'h0F0;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    s = e + LAT;
    wait_cyc(s + 17);
    check("t4_pre_line", ser[0], 1'b0);
    #2 rst_n = 1'b0;
    #1 check("t4_rst_out", {ser[0], act[0], dn[0], rdy[0]}, 4'b1001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = cyc + 1;
    bq[0] = 9'h081;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    s = e + LAT;
    wait_cyc(s + 62);
    frame_lit("t4_81_bits", 0, s, 16'h0302, 10);
    done_lit("t4_81", 0, s, 40);

    w  = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    fl = '{16'h0222, 16'h0244, 16'h0266, 16'h0288, 16'h02AA};
    k  = 0;
    e  = cyc + 1;
    bq[0] = w[0];
    dv[0] = 1'b1;
    while (k < 5 && cyc < e + 400) begin
      @(negedge clk);
      if (acc[0]) k++;
      if (k < 5) bq[0] = w[k];
      else dv[0] = 1'b0;
    end
    dv[0] = 1'b0;
    check("t5_accepted", k, 5);
    s = e + LAT;
    wait_cyc(s + 5*41 + 5);
    check("t5_ready_low", lrdy[0][e+4], 1'b0);
    for (int j = 0; j < 5; j++)
      frame_lit($sformatf("t5_frame%0d", j), 0, s + j*41, fl[j], 10);
    k = 0;
    for (int j = s; j <= s + 5*41 + 2; j++) if (ldn[0][j]) k++;
    check("t5_done_count", k, 5);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
